// File: rtl/timer_pkg.sv
// Shared constants and helpers for the timer prescaler (RTL and benches).
package timer_pkg;

    localparam int CKS_DIV2    = 0;
    localparam int CKS_DIV4    = 1;
    localparam int CKS_DIV8    = 2;
    localparam int CKS_DIV16   = 3;
    localparam int TIMER_DIV_W = 4;
    localparam int TIMER_SEL_W = 2;

    // Strobe period in clk cycles for divide select k.
    function automatic int div_period(input int k);
        return 1 << (k + 1);
    endfunction

endpackage

// File: rtl/timer_clk_div_if.sv
// Control/strobe bundle between the timer control register and the prescaler.
// Optional ext_tick/ext_sel signals exist only with TIMER_CLK_DIV_EXT_TICK_EN.
interface timer_clk_div_if
    import timer_pkg::*;
#(
    parameter int SEL_W = TIMER_SEL_W,
    parameter int DIV_W = TIMER_DIV_W
);

    logic [SEL_W-1:0] cks;
    logic             div_en;
    logic             clk_ena;
    logic [DIV_W-1:0] div_cnt;
`ifdef TIMER_CLK_DIV_EXT_TICK_EN
    logic             ext_tick;
    logic             ext_sel;

    modport master (output cks, div_en, ext_tick, ext_sel, input clk_ena, div_cnt);
    modport slave  (input cks, div_en, ext_tick, ext_sel, output clk_ena, div_cnt);
`else
    modport master (output cks, div_en, input clk_ena, div_cnt);
    modport slave  (input cks, div_en, output clk_ena, div_cnt);
`endif

endinterface

// File: rtl/timer_edge_det.sv
// Registered rising-edge detector with hold enable and synchronous clear.
module timer_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic d,
    output logic pulse
);

    logic d_q;

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            d_q   <= 1'b0;
            pulse <= 1'b0;
        end else if (clr) begin
            d_q   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= en & d & ~d_q;
            if (en) d_q <= d;
        end
    end

endmodule

// File: rtl/timer_clk_div.sv
// Timer prescaler: divides clk by 2/4/8/16 into a one-cycle clk_ena strobe.
// Define TIMER_CLK_DIV_EXT_TICK_EN to add a synchronized external tick source.
module timer_clk_div
    import timer_pkg::*;
#(
    parameter int DIV_W = TIMER_DIV_W,
    parameter int SEL_W = TIMER_SEL_W
) (
    input  logic            clk,
    input  logic            rst_n,
    timer_clk_div_if.slave  bus
);

    logic [DIV_W-1:0] div_cnt;
    logic [SEL_W-1:0] cks_q;
    logic             restart;
    logic             tap;
    logic             div_pulse;

    // NOTE: default assignment first keeps this combinational block latch-free.
    // Selects at or beyond the top tap fall through to div_cnt[DIV_W-1].
    always_comb begin
        tap = div_cnt[DIV_W-1];
        for (int i = 0; i < DIV_W - 1; i++) begin
            if (int'(cks_q) == i) tap = div_cnt[i];
        end
    end

`ifdef TIMER_CLK_DIV_EXT_TICK_EN
    logic ext_sel_q;
    logic tick_s1;
    logic tick_s2;
    logic ext_pulse;

    assign restart = (bus.cks != cks_q) | (bus.ext_sel != ext_sel_q);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            tick_s1   <= 1'b0;
            tick_s2   <= 1'b0;
            ext_sel_q <= 1'b0;
        end else begin
            tick_s1   <= bus.ext_tick;
            tick_s2   <= tick_s1;
            ext_sel_q <= bus.ext_sel;
        end
    end

    timer_edge_det u_ext_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.div_en),
        .clr   (restart),
        .d     (tick_s2),
        .pulse (ext_pulse)
    );

    // Both sources are flop outputs and the select is registered, so no input reaches clk_ena.
    assign bus.clk_ena = ext_sel_q ? ext_pulse : div_pulse;
`else
    assign restart     = (bus.cks != cks_q);
    assign bus.clk_ena = div_pulse;
`endif

    always_ff @(posedge clk) begin
        if (rst_n) begin
            div_cnt <= '0;
            cks_q   <= '0;
        end else begin
            cks_q <= bus.cks;
            if (restart)         div_cnt <= '0;
            else if (bus.div_en) div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    timer_edge_det u_tap_det (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.div_en),
        .clr   (restart),
        .d     (tap),
        .pulse (div_pulse)
    );

    assign bus.div_cnt = div_cnt;

endmodule

// File: tb/tb_timer_clk_div.sv
// Directed self-checking bench for timer_clk_div (ext tick section with TIMER_CLK_DIV_EXT_TICK_EN).
module tb_timer_clk_div;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    timer_clk_div_if #(.SEL_W(TIMER_SEL_W), .DIV_W(TIMER_DIV_W)) bus ();

    timer_clk_div #(.DIV_W(TIMER_DIV_W), .SEL_W(TIMER_SEL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe expected in the cycle after edge n (edges counted from restart) for select k.
    function automatic bit exp_strobe(input int n, input int k);
        int first;
        first = (1 << k) + 1;
        return (n >= first) && (((n - first) % div_period(k)) == 0);
    endfunction

    initial begin
        int m;
        int last;
        int strobes;
        bit en;

        rst_n      = 1'b1;
        bus.cks    = 2'(CKS_DIV2);
        bus.div_en = 1'b1;
`ifdef TIMER_CLK_DIV_EXT_TICK_EN
        bus.ext_tick = 1'b0;
        bus.ext_sel  = 1'b0;
`endif

        // Reset held for 5 clk
        repeat (5) begin
            tick();
            check("rst_ena", 32'(bus.clk_ena), 32'd0);
            check("rst_cnt", 32'(bus.div_cnt), 32'd0);
        end
        rst_n = 1'b0;

        // /2 from reset release
        for (int n = 1; n <= 20; n++) begin
            tick();
            check("div2_ena", 32'(bus.clk_ena), 32'(exp_strobe(n, 0)));
            check("div2_cnt", 32'(bus.div_cnt), 32'(n % 16));
        end

        // Reset for one clk while the strobe is high
        check("pre_rst_ena", 32'(bus.clk_ena), 32'd1);
        rst_n = 1'b1;
        tick();
        check("mid_rst_ena", 32'(bus.clk_ena), 32'd0);
        check("mid_rst_cnt", 32'(bus.div_cnt), 32'd0);
        rst_n = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check("post_rst_ena", 32'(bus.clk_ena), 32'(exp_strobe(n, 0)));
        end

        // /16 for 64 clk
        bus.cks = 2'(CKS_DIV16);
        tick();
        check("sw16_ena", 32'(bus.clk_ena), 32'd0);
        check("sw16_cnt", 32'(bus.div_cnt), 32'd0);
        strobes = 0;
        last    = -1;
        for (int n = 1; n <= 64; n++) begin
            tick();
            check("div16_ena", 32'(bus.clk_ena), 32'(exp_strobe(n, 3)));
            if (bus.clk_ena === 1'b1) begin
                if (last >= 0) check("div16_gap", 32'(n - last), 32'd16);
                else           check("div16_first", 32'(n), 32'd9);
                last = n;
                strobes++;
            end
        end
        check("div16_count", 32'(strobes), 32'd4);

        // /4 with div_en dropped for 7 clk mid-period
        bus.cks = 2'(CKS_DIV4);
        tick();
        check("sw4_cnt", 32'(bus.div_cnt), 32'd0);
        m = 0;
        for (int t = 1; t <= 30; t++) begin
            en         = !(t >= 5 && t <= 11);
            bus.div_en = en;
            tick();
            if (en) m++;
            check("div4_ena", 32'(bus.clk_ena), en ? 32'(exp_strobe(m, 1)) : 32'd0);
            check("div4_cnt", 32'(bus.div_cnt), 32'(m % 16));
        end
        bus.div_en = 1'b1;

        // Switch /2 -> /8 on the edge a /2 strobe would fire
        bus.cks = 2'(CKS_DIV2);
        tick();
        for (int n = 1; n <= 3; n++) begin
            tick();
            check("pre_sw_ena", 32'(bus.clk_ena), 32'(exp_strobe(n, 0)));
        end
        bus.cks = 2'(CKS_DIV8);
        tick();
        check("sw8_glitch", 32'(bus.clk_ena), 32'd0);
        check("sw8_cnt", 32'(bus.div_cnt), 32'd0);
        for (int n = 1; n <= 22; n++) begin
            tick();
            check("div8_ena", 32'(bus.clk_ena), 32'(exp_strobe(n, 2)));
        end

        // Select change while disabled still restarts
        bus.div_en = 1'b0;
        bus.cks    = 2'(CKS_DIV4);
        repeat (4) begin
            tick();
            check("dis_sw_cnt", 32'(bus.div_cnt), 32'd0);
            check("dis_sw_ena", 32'(bus.clk_ena), 32'd0);
        end
        bus.div_en = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            tick();
            check("dis_sw_div4", 32'(bus.clk_ena), 32'(exp_strobe(n, 1)));
        end

`ifdef TIMER_CLK_DIV_EXT_TICK_EN
        // External tick source: two 3-clk pulses, strobe 3 clk after each rise
        bus.ext_sel = 1'b1;
        tick();
        check("ext_sw_ena", 32'(bus.clk_ena), 32'd0);
        strobes = 0;
        repeat (2) begin
            bus.ext_tick = 1'b1;
            for (int n = 1; n <= 8; n++) begin
                tick();
                if (n == 3) bus.ext_tick = 1'b0;
                check("ext_ena", 32'(bus.clk_ena), 32'(n == 3));
                if (bus.clk_ena === 1'b1) strobes++;
            end
        end
        check("ext_count", 32'(strobes), 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_clk_div.md
Name: timer_clk_div

Overview:
- Clock-enable generator (prescaler) that produces the single-cycle `clk_ena` strobe consumed by the 8-bit timer `counter` block.
- Divides `clk` by 2/4/8/16, selected by `cks`, using a free-running divide counter with rising-edge detection of the selected tap.
- Sits between the timer control register (source of `cks`/`div_en`) and `counter.clk_ena`.

Parameters:
- DIV_W, 4, divide-counter width; tap k = div_cnt[k], k in 0..DIV_W-1.
- SEL_W, 2, width of the `cks` select; must satisfy 2^SEL_W <= DIV_W.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous reset, active-high (asserted when 1). Port name kept as the codebase does.
- cks  input  SEL_W  divide select: 0 -> /2, 1 -> /4, 2 -> /8, 3 -> /16.
- div_en  input  1  prescaler run enable.
- clk_ena  output  1  one-clk-wide enable strobe to `counter`.
- div_cnt  output  DIV_W  current divide-counter value (debug/readback).

Behaviour:
- Reset (rst_n=1 at posedge clk):
  - div_cnt=0, tap_d=0, cks_q=0, clk_ena=0.
  - Reset has priority over all other inputs, including mid-count and mid-pulse.
- Counter:
  - div_cnt increments by 1 on each clk while div_en=1.
  - Wraps 2^DIV_W-1 -> 0 modulo; no saturation.
- Edge detect:
  - tap = div_cnt[cks_q]. tap_d <= tap every cycle that div_en=1.
  - clk_ena <= div_en & tap & ~tap_d. The output is registered, so there is no combinational path from inputs.
- Timing for cks=k, measured from reset release (or restart) with div_en=1:
  - First strobe is high in the cycle after edge 2^k+1.
  - After that, strobes repeat every 2^(k+1) clocks.
  - Each strobe is exactly 1 clk wide.
- div_en=0:
  - div_cnt and tap_d hold their values; clk_ena=0 on the next edge.
  - Re-enable resumes from the held phase; no extra or lost pulse is generated.
- cks change:
  - cks is registered into cks_q. When cks != cks_q, on that edge: div_cnt<=0, tap_d<=0, clk_ena<=0, cks_q<=cks.
  - Result: no glitch pulse, and the new period starts cleanly per the first-strobe rule above.
- Simultaneous cks change and div_en=0: restart still occurs; counting begins when div_en rises.
- cks value >= DIV_W (only possible with a non-default SEL_W): treated as DIV_W-1.

Optional Feature:
- Macro: TIMER_CLK_DIV_EXT_TICK_EN.
- When defined:
  - Adds ports `ext_tick` (input, 1) and `ext_sel` (input, 1).
  - ext_tick passes through a 2-FF synchronizer, then rising-edge detection.
  - When ext_sel=1, clk_ena = registered synchronized rising edge of ext_tick, gated by div_en. The internal divider keeps counting.
  - Latency is 3 clk from the ext_tick rise to the clk_ena strobe.
  - Toggling ext_sel triggers the same restart as a cks change.
- When undefined: neither port exists; behaviour is the internal divider only.

Decomposition:
- Package timer_pkg holds:
  - localparams CKS_DIV2=0, CKS_DIV4=1, CKS_DIV8=2, CKS_DIV16=3;
  - TIMER_DIV_W=4;
  - function div_period(k) = 2^(k+1), shared with benches.
- One sub-module, timer_edge_det:
  - Registered rising-edge detector with hold enable and synchronous clear.
  - Instantiated for the divider tap and, with the macro defined, for ext_tick.

Test Plan:
- Reset held 5 clk, then released with cks=0, div_en=1 -> clk_ena=0 during reset; first strobe in cycle after edge 2; strobes every 2 clk for 20 clk; width always 1.
- cks=3 for 64 clk -> exactly 4 strobes, 16 clk apart; first after edge 9.
- Run with cks=1; drop div_en for 7 clk mid-period, then raise it -> no strobe while low; div_cnt frozen; next strobe lands at the remaining phase (total enabled-clk gap = 4).
- Switch cks 0->2 in the same cycle a /2 strobe would fire -> no strobe that cycle; div_cnt=0 next cycle; next strobe after edge 5 from the switch, then every 8.
- Assert rst_n for 1 clk while clk_ena=1 -> clk_ena=0 and div_cnt=0 next cycle; sequence restarts per the first-strobe rule.
- TIMER_CLK_DIV_EXT_TICK_EN with ext_sel=1; ext_tick pulsed high for 3 clk, twice -> exactly 2 strobes, each 3 clk after the ext_tick rise; no strobes from the internal divider.
